// File: rtl/pwm_fade_sequencer.sv
// Fades a bank of PWM channels toward per-channel target duties, one step per
// tick, issuing each duty change as a write on a shared downstream bus.
module pwm_fade_sequencer #(
  parameter int unsigned pClkHz    = 12_000_000,
  parameter int unsigned pStepHz   = 1_000,
  parameter int unsigned pChannels = 4,
  parameter int unsigned pStepSize = 1,
  localparam int unsigned AW = (pChannels > 1) ? $clog2(pChannels) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_stb_i,
  input  logic [AW-1:0]        cfg_adr_i,
  input  logic [7:0]           cfg_dat_i,
  output logic                 cfg_ack_o,
  output logic                 pwm_stb_o,
  output logic [pChannels-1:0] pwm_sel_o,
  output logic [7:0]           pwm_dat_o,
  input  logic                 pwm_ack_i,
  output logic                 busy_o
);

  // state    | meaning
  // ST_IDLE  | waiting for a step tick (or a pending pass)
  // ST_SCAN  | comparing cur/tgt of channel idx, latching the next duty
  // ST_WRITE | downstream write of nxt to channel idx, waiting for ack

  localparam int unsigned TICKS = pClkHz / pStepHz;
  localparam int unsigned CW    = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(pChannels - 1);
  localparam logic [8:0]    STEP9    = 9'(pStepSize);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick;
  logic            pending_q, pending_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [7:0]      nxt_q, nxt_d;
  logic [7:0]      nxt_calc;
  logic [7:0]      tgt_q [pChannels];
  logic [7:0]      cur_q [pChannels];
  logic            cur_wr;
  logic            chan_done;
  logic            differ;
  logic            cfg_hit;
  logic [8:0]      cur9, tgt9;

  // Step tick
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Config port: out-of-range channel indices are acknowledged and dropped
  assign cfg_ack_o = cfg_stb_i;
  assign cfg_hit   = cfg_stb_i && (32'(cfg_adr_i) < pChannels);

  // One step toward the target without overshoot, in 9 bits so nothing wraps
  always_comb begin
    cur9     = {1'b0, cur_q[idx_q]};
    tgt9     = {1'b0, tgt_q[idx_q]};
    nxt_calc = tgt_q[idx_q];
    if (tgt9 > cur9) begin
      if ((tgt9 - cur9) > STEP9) nxt_calc = 8'(cur9 + STEP9);
    end else begin
      if ((cur9 - tgt9) > STEP9) nxt_calc = 8'(cur9 - STEP9);
    end
  end

  always_comb begin
    differ = 1'b0;
    for (int i = 0; i < int'(pChannels); i++) begin
      if (cur_q[i] != tgt_q[i]) differ = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nxt_d     = nxt_q;
    pending_d = pending_q;
    cur_wr    = 1'b0;
    chan_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (tick) pending_d = 1'b1;
        if (cur_q[idx_q] == tgt_q[idx_q]) begin
          chan_done = 1'b1;
        end else begin
          nxt_d   = nxt_calc;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (tick) pending_d = 1'b1;
        if (pwm_ack_i) begin
          cur_wr    = 1'b1;
          chan_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A tick landing on the pass end while already pending is dropped
    if (chan_done) begin
      if (idx_q == IDX_LAST) begin
        if (pending_q) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_SCAN;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    pwm_stb_o = (state_q == ST_WRITE);
    pwm_dat_o = (state_q == ST_WRITE) ? nxt_q : 8'h00;
    pwm_sel_o = '0;
    for (int i = 0; i < int'(pChannels); i++) begin
      pwm_sel_o[i] = (state_q == ST_WRITE) && (idx_q == AW'(i));
    end
    busy_o = (state_q != ST_IDLE) || differ;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      nxt_q     <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      nxt_q     <= nxt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(pChannels); i++) begin
        tgt_q[i] <= 8'h00;
        cur_q[i] <= 8'h00;
      end
    end else begin
      if (cfg_hit) tgt_q[cfg_adr_i] <= cfg_dat_i;
      if (cur_wr)  cur_q[idx_q]     <= nxt_q;
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer: ramps, large-step clamping, skipping,
// ack stalls with pending passes, mid-write config and reset.
module tb_pwm_fade_sequencer;

  localparam int TICKS = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       cfg_stb_a = 1'b0, cfg_ack_a;
  logic [1:0] cfg_adr_a = '0;
  logic [7:0] cfg_dat_a = '0;
  logic       stb_a, ack_a, busy_a;
  logic [3:0] sel_a;
  logic [7:0] dat_a;
  logic       hold_a = 1'b0;

  logic       cfg_stb_b = 1'b0, cfg_ack_b;
  logic [1:0] cfg_adr_b = '0;
  logic [7:0] cfg_dat_b = '0;
  logic       stb_b, ack_b, busy_b;
  logic [2:0] sel_b;
  logic [7:0] dat_b;

  logic [3:0] a_sel [$];
  logic [7:0] a_dat [$];
  int         a_cyc [$];
  logic [2:0] b_sel [$];
  logic [7:0] b_dat [$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  pwm_fade_sequencer #(.pClkHz(20), .pStepHz(1), .pChannels(4), .pStepSize(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .cfg_stb_i(cfg_stb_a), .cfg_adr_i(cfg_adr_a), .cfg_dat_i(cfg_dat_a), .cfg_ack_o(cfg_ack_a),
    .pwm_stb_o(stb_a), .pwm_sel_o(sel_a), .pwm_dat_o(dat_a), .pwm_ack_i(ack_a),
    .busy_o(busy_a)
  );

  pwm_fade_sequencer #(.pClkHz(20), .pStepHz(1), .pChannels(3), .pStepSize(100)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .cfg_stb_i(cfg_stb_b), .cfg_adr_i(cfg_adr_b), .cfg_dat_i(cfg_dat_b), .cfg_ack_o(cfg_ack_b),
    .pwm_stb_o(stb_b), .pwm_sel_o(sel_b), .pwm_dat_o(dat_b), .pwm_ack_i(ack_b),
    .busy_o(busy_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream slaves: ack one cycle after stb is seen; each ack completes a write
  initial begin
    ack_a = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (stb_a && !hold_a && !ack_a) begin
        ack_a = 1'b1;
        a_sel.push_back(sel_a);
        a_dat.push_back(dat_a);
        a_cyc.push_back(cyc);
      end else begin
        ack_a = 1'b0;
      end
    end
  end

  initial begin
    ack_b = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (stb_b && !ack_b) begin
        ack_b = 1'b1;
        b_sel.push_back(sel_b);
        b_dat.push_back(dat_b);
      end else begin
        ack_b = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_a(input logic [1:0] adr, input logic [7:0] dat);
    @(negedge clk);
    cfg_stb_a = 1'b1; cfg_adr_a = adr; cfg_dat_a = dat;
    #1 chk("a_cfg_ack", cfg_ack_a, 1'b1);
    @(negedge clk);
    cfg_stb_a = 1'b0;
  endtask

  task automatic cfg_b(input logic [1:0] adr, input logic [7:0] dat);
    @(negedge clk);
    cfg_stb_b = 1'b1; cfg_adr_b = adr; cfg_dat_b = dat;
    #1 chk("b_cfg_ack", cfg_ack_b, 1'b1);
    @(negedge clk);
    cfg_stb_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (busy_a && n < budget) begin @(negedge clk); n++; end
    chk("a_idle_in_time", (n < budget), 1'b1);
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    while (busy_b && n < budget) begin @(negedge clk); n++; end
    chk("b_idle_in_time", (n < budget), 1'b1);
  endtask

  task automatic wait_stb_a(input int budget);
    int n = 0;
    while (!stb_a && n < budget) begin @(negedge clk); n++; end
    chk("a_stb_in_time", (n < budget), 1'b1);
  endtask

  task automatic wait_writes_a(input int cnt, input int budget);
    int n = 0;
    while (a_dat.size() < cnt && n < budget) begin @(negedge clk); n++; end
    chk("a_writes_in_time", (n < budget), 1'b1);
  endtask

  task automatic clear_a();
    a_sel.delete(); a_dat.delete(); a_cyc.delete();
  endtask

  initial begin
    int n0, n3, nx, last0, last3, unstable, rel;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stb", stb_a, 1'b0);
    chk("rst_sel", sel_a, 4'h0);
    chk("rst_dat", dat_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    rst = 1'b0;

    // Large step: ramps clamp at 0xFF and 0x00
    cfg_b(2'd2, 8'hFF);
    wait_idle_b(500);
    chk("b_up_count", b_dat.size(), 3);
    if (b_dat.size() == 3) begin
      chk("b_up0", b_dat[0], 8'h64);
      chk("b_up1", b_dat[1], 8'hC8);
      chk("b_up2", b_dat[2], 8'hFF);
      chk("b_up_sel", b_sel[2], 3'b100);
    end
    b_sel.delete(); b_dat.delete();
    cfg_b(2'd2, 8'h00);
    wait_idle_b(500);
    chk("b_dn_count", b_dat.size(), 3);
    if (b_dat.size() == 3) begin
      chk("b_dn0", b_dat[0], 8'h9B);
      chk("b_dn1", b_dat[1], 8'h37);
      chk("b_dn2", b_dat[2], 8'h00);
    end
    b_sel.delete(); b_dat.delete();
    cfg_b(2'd3, 8'h55);
    repeat (2 * TICKS) @(negedge clk);
    chk("b_oob_busy", busy_b, 1'b0);
    chk("b_oob_writes", b_dat.size(), 0);

    // Single channel ramp, one write per tick
    clear_a();
    cfg_a(2'd0, 8'h10);
    wait_idle_a(1000);
    chk("t1_count", a_dat.size(), 16);
    for (int i = 0; i < a_dat.size() && i < 16; i++) begin
      chk("t1_sel", a_sel[i], 4'b0001);
      chk("t1_dat", a_dat[i], 8'(i + 1));
      if (i > 0) chk("t1_gap", a_cyc[i] - a_cyc[i-1], TICKS);
    end
    repeat (3 * TICKS) @(negedge clk);
    chk("t1_no_more", a_dat.size(), 16);
    chk("t1_stb_low", stb_a, 1'b0);

    // Two channels in one pass; idle channels skipped
    clear_a();
    cfg_a(2'd0, 8'h05);
    cfg_a(2'd3, 8'h09);
    wait_idle_a(1000);
    chk("t3_count", a_dat.size(), 20);
    n0 = 0; n3 = 0; nx = 0; last0 = 0; last3 = 0;
    for (int i = 0; i < a_dat.size(); i++) begin
      if (a_sel[i] == 4'b0001) begin n0++; last0 = a_dat[i]; end
      else if (a_sel[i] == 4'b1000) begin n3++; last3 = a_dat[i]; end
      else nx++;
    end
    if (a_dat.size() >= 2) begin
      chk("t3_first_sel", a_sel[0], 4'b0001);
      chk("t3_first_dat", a_dat[0], 8'h0F);
      chk("t3_second_sel", a_sel[1], 4'b1000);
      chk("t3_second_dat", a_dat[1], 8'h01);
    end
    chk("t3_n0", n0, 11);
    chk("t3_n3", n3, 9);
    chk("t3_other", nx, 0);
    chk("t3_last0", last0, 5);
    chk("t3_last3", last3, 9);

    // Bring channel 1 to 0x40
    clear_a();
    cfg_a(2'd1, 8'h40);
    wait_idle_a(2000);
    chk("ramp_count", a_dat.size(), 64);
    if (a_dat.size() > 0) chk("ramp_last", a_dat[a_dat.size()-1], 8'h40);

    // Stalled write: stable bus, mid-write retarget, one pending pass
    clear_a();
    hold_a = 1'b1;
    cfg_a(2'd1, 8'h41);
    wait_stb_a(100);
    chk("t4_sel", sel_a, 4'b0010);
    chk("t4_dat", dat_a, 8'h41);
    cfg_a(2'd1, 8'h80);
    unstable = 0;
    for (int i = 0; i < 3 * TICKS; i++) begin
      @(negedge clk);
      if (stb_a !== 1'b1 || sel_a !== 4'b0010 || dat_a !== 8'h41) unstable++;
    end
    chk("t4_stable", unstable, 0);
    chk("t4_no_complete", a_dat.size(), 0);
    hold_a = 1'b0;
    rel = cyc;
    wait_writes_a(2, 100);
    if (a_dat.size() >= 2) begin
      chk("t5_held_dat", a_dat[0], 8'h41);
      chk("t5_next_dat", a_dat[1], 8'h42);
      chk("t4_pending_fast", (a_cyc[1] - rel) <= 10, 1'b1);
    end
    wait_writes_a(3, 100);
    if (a_dat.size() >= 3) begin
      chk("t4_third_dat", a_dat[2], 8'h43);
      chk("t4_extra_dropped", (a_cyc[2] - a_cyc[1]) >= 10, 1'b1);
    end

    // Reset in the middle of a write
    hold_a = 1'b1;
    wait_stb_a(100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_stb", stb_a, 1'b0);
    chk("t6_sel", sel_a, 4'h0);
    chk("t6_dat", dat_a, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hold_a = 1'b0;
    clear_a();
    @(negedge clk);
    chk("t6_busy", busy_a, 1'b0);
    repeat (2 * TICKS) @(negedge clk);
    chk("t6_no_writes", a_dat.size(), 0);
    cfg_a(2'd1, 8'h01);
    wait_idle_a(200);
    chk("t6_post_count", a_dat.size(), 1);
    if (a_dat.size() == 1) begin
      chk("t6_post_sel", a_sel[0], 4'b0010);
      chk("t6_post_dat", a_dat[0], 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
